// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: memory target serving 8-beat line reads and writes over sysbus.
`ifndef SYSBUS_READ
`define SYSBUS_READ 4'h1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 4'h2
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1'b1
`endif
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [2:0] IDLE = 3'd0, ACK = 3'd1, WAIT = 3'd2, RESP = 3'd3, WDATA = 3'd4;
  logic [2:0] state;
  logic [2:0] beat;
  logic [LW-1:0] lat_cnt;
  logic [AW-4:0] line;
  logic [BUS_TAG_WIDTH-1:0] tag;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic is_mem, is_rd, is_wr;
  assign idx = {line, beat};
  assign is_mem = tag[12] == `SYSBUS_MEMORY;
  assign is_rd = is_mem && tag[11:8] == `SYSBUS_READ;
  assign is_wr = is_mem && tag[11:8] == `SYSBUS_WRITE;
  assign bus_reqack = state == ACK || (state == WDATA && bus_reqcyc);
  assign bus_respcyc = state == RESP;
  assign bus_resp = bus_respcyc ? mem[idx] : '0;
  assign bus_resptag = bus_respcyc ? tag : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      lat_cnt <= '0;
      line <= '0;
      tag <= '0;
    end else begin
      case (state)
        IDLE: if (bus_reqcyc) begin
          state <= ACK;
          line <= bus_req[AW+2:6];
          tag <= bus_reqtag;
        end
        ACK: begin
          beat <= '0;
          lat_cnt <= '0;
          state <= is_rd ? (LATENCY == 1 ? RESP : WAIT) : is_wr ? WDATA : IDLE;
        end
        WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LW'(LATENCY - 2)) state <= RESP;
        end
        RESP: if (bus_respack) begin
          beat <= beat + 1'b1;
          if (beat == 3'd7) state <= IDLE;
        end
        WDATA: if (bus_reqcyc) begin
          beat <= beat + 1'b1;
          if (beat == 3'd7) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (state == WDATA && bus_reqcyc) mem[idx] <= bus_req;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: scoreboard bench for line reads/writes, latency, wrap, reset abort and request blocking.
module tb_sysbus_mem_responder;
  localparam logic [3:0] RD = 4'h1, WR = 4'h2;
  localparam logic [12:0] RD_TAG = {1'b1, RD, 8'h5A};
  localparam logic [12:0] WR_TAG = {1'b1, WR, 8'h33};
  localparam logic [12:0] BAD_TAG = {1'b0, RD, 8'h77};
  typedef struct {
    logic [63:0] d;
    logic [12:0] t;
  } exp_t;
  logic clk = 0, reset = 1;
  logic bus_reqcyc = 0, bus_reqack, bus_respcyc, bus_respack = 1;
  logic [63:0] bus_req = '0, bus_resp;
  logic [12:0] bus_reqtag = '0, bus_resptag;
  logic tog = 0;
  logic [63:0] model [1024];
  exp_t exp_q[$];
  int n_checks = 0, n_errors = 0, n_beats = 0;
  sysbus_mem_responder dut (
    .clk(clk), .reset(reset), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    bus_respack = tog ? ~bus_respack : 1'b1;
  end
  always @(negedge clk) begin
    if (bus_respcyc) begin
      if (exp_q.size() == 0) check("extra_beat", 64'(bus_respcyc), 0);
      else begin
        check("beat_data", bus_resp, exp_q[0].d);
        check("beat_tag", 64'(bus_resptag), 64'(exp_q[0].t));
        if (bus_respack) begin
          void'(exp_q.pop_front());
          n_beats++;
        end
      end
    end else check("resp_idle_zero", bus_resp | 64'(bus_resptag), 0);
  end
  task automatic send_req(input logic [63:0] a, input logic [12:0] t);
    int n = 0;
    bus_req = a;
    bus_reqtag = t;
    bus_reqcyc = 1;
    do begin @(negedge clk); n++; end while (!bus_reqack && n < 50);
    check("req_ack", 64'(bus_reqack), 1);
    @(posedge clk); #1;
    bus_reqcyc = 0;
  endtask
  task automatic push_line(input logic [63:0] a, input logic [12:0] t);
    for (int i = 0; i < 8; i++) exp_q.push_back('{model[{a[12:6], i[2:0]}], t});
  endtask
  task automatic wr(input logic [63:0] a, input logic [63:0] base_d);
    send_req(a, WR_TAG);
    for (int i = 0; i < 8; i++) begin
      bus_req = base_d + 64'(i);
      bus_reqcyc = 1;
      @(negedge clk);
      check("wr_ack", 64'(bus_reqack), 1);
      model[{a[12:6], i[2:0]}] = base_d + 64'(i);
      @(posedge clk); #1;
    end
    bus_reqcyc = 0;
    @(negedge clk);
    check("wr_done", 64'(bus_reqack | bus_respcyc), 0);
  endtask
  task automatic rd(input logic [63:0] a, input logic [12:0] t);
    int lat = 0, n = 0, b0 = n_beats;
    push_line(a, t);
    send_req(a, t);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("ack_pulse", 64'(bus_reqack), 0);
    end while (!bus_respcyc && lat < 50);
    check("latency", 64'(lat), 4);
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("beat_count", 64'(n_beats - b0), 8);
    @(negedge clk);
    check("respcyc_drop", 64'(bus_respcyc), 0);
  endtask
  initial begin
    int n, early;
    #3;
    check("rst_reqack", 64'(bus_reqack), 0);
    check("rst_respcyc", 64'(bus_respcyc), 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    wr(64'h0, 64'd1);
    wr(64'h40, 64'd9);
    rd(64'h0, RD_TAG);
    tog = 1;
    rd(64'h47, {1'b1, RD, 8'hC3});
    tog = 0;
    wr(64'h80, 64'hA0);
    rd(64'h80, {1'b1, RD, 8'h01});
    rd(64'h2000, {1'b1, RD, 8'h02});
    push_line(64'h0, {1'b1, RD, 8'h03});
    send_req(64'h0, {1'b1, RD, 8'h03});
    n = 0;
    while (!bus_respcyc && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_cyc", 64'(bus_respcyc), 1);
    #1 reset = 1;
    #1;
    check("abort_respcyc", 64'(bus_respcyc), 0);
    check("abort_resp", bus_resp, 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 0;
    rd(64'h0, {1'b1, RD, 8'h04});
    push_line(64'h40, {1'b1, RD, 8'h05});
    send_req(64'h40, {1'b1, RD, 8'h05});
    bus_req = 64'h80;
    bus_reqtag = BAD_TAG;
    bus_reqcyc = 1;
    n = 0;
    early = 0;
    do begin
      @(negedge clk);
      n++;
      if (exp_q.size() != 0) early += int'(bus_reqack);
    end while (!bus_reqack && n < 200);
    check("blocked_ack", 64'(early), 0);
    check("ack_after_idle", 64'(exp_q.size()), 0);
    check("bad_acked", 64'(bus_reqack), 1);
    @(posedge clk); #1;
    bus_reqcyc = 0;
    n = 0;
    early = 0;
    repeat (12) begin
      @(negedge clk);
      n += int'(bus_respcyc);
      early += int'(bus_reqack);
    end
    check("bad_no_resp", 64'(n), 0);
    check("bad_one_ack", 64'(early), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BUS_DATA_WIDTH, 64, bus data/address width.
- BUS_TAG_WIDTH, 13, tag width.
- MEM_WORDS, 1024, backing store depth in 64-bit words (power of 2).
- LATENCY, 4, cycles from request ack to first response beat (>=1).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- bus_reqcyc, in, 1, initiator request valid.
- bus_req, in, BUS_DATA_WIDTH, request address, or write data beat.
- bus_reqtag, in, BUS_TAG_WIDTH, request tag; [11:8] command, [12] device.
- bus_reqack, out, 1, request/beat accepted.
- bus_respcyc, out, 1, response beat valid.
- bus_resp, out, BUS_DATA_WIDTH, response data beat.
- bus_resptag, out, BUS_TAG_WIDTH, echo of the accepted request tag.
- bus_respack, in, 1, initiator consumed the current beat.
REQ-003 One clock, clk; reset is asynchronous and active-high on port reset.

Function
REQ-004 FSM states: IDLE, ACK, WAIT, RESP, WDATA; next state is decided only at rising clk edges.
REQ-005 In IDLE with bus_reqcyc=1: latch bus_req and bus_reqtag, go to ACK; bus_reqack=1 for exactly that one cycle.
REQ-006 Line base = latched address with bits [5:0] cleared; 8 beats per line; word index = (base>>3 + beat) mod MEM_WORDS, so addresses wrap.
REQ-007 Read path (tag[11:8] == `SYSBUS_READ`, tag[12] == `SYSBUS_MEMORY`): ACK -> WAIT.
REQ-008 WAIT: count LATENCY-1 cycles, then go to RESP; the first beat is valid exactly LATENCY cycles after the bus_reqack cycle.
REQ-009 RESP: bus_respcyc=1, bus_resp=mem[word index], bus_resptag=latched tag.
- Beat held stable while bus_respack=0.
- Beat advances when bus_respack=1 at the edge.
- After beat 7 is accepted: bus_respcyc=0 next cycle, return to IDLE.
REQ-010 Write path (tag[11:8] == `SYSBUS_WRITE`, memory device): ACK -> WDATA.
- Each cycle with bus_reqcyc=1: store bus_req into beat index and pulse bus_reqack that cycle.
- After 8 beats: return to IDLE.
- No response beats are produced for a write.
REQ-011 Any other command/device: ack the address, discard it, return to IDLE; no response.
REQ-012 While not in IDLE, new requests are not acked; bus_reqcyc is ignored except as write data in WDATA.
REQ-013 bus_resp and bus_resptag are 0 whenever bus_respcyc=0.
REQ-014 Simultaneous final-beat accept and a new bus_reqcyc: the new request is acked no earlier than the first cycle spent back in IDLE.
REQ-015 Write-then-read of the same line returns the written data, with no stale beats.

Reset
REQ-016 On reset assertion, outputs go to 0 immediately, without waiting for clk: bus_reqack, bus_respcyc, bus_resp, bus_resptag; FSM goes to IDLE; beat and latency counters are cleared.
REQ-017 Reset mid-read or mid-write aborts the transaction; memory words already written keep their values; no reset of the memory array is required.
REQ-018 First request is accepted no earlier than the first clk edge after reset deasserts.

Verification
REQ-019 Preload mem[0..7]=1..8, read addr 0x0 with respack tied 1 -> reqack one cycle; respcyc 4 cycles later; beats 1..8 on consecutive cycles; resptag echoes request tag.
REQ-020 Read addr 0x47 with respack toggling 1,0,1,0 -> beats mem[8..15] in order; each beat held while respack=0; exactly 8 beats total.
REQ-021 Write addr 0x80, data 0xA0..0xA7, then read 0x80 -> 8 reqack pulses on the write, then read returns 0xA0..0xA7.
REQ-022 Read addr MEM_WORDS*8 (wraps) -> beats equal mem[0..7].
REQ-023 Assert reset during beat 3 of a read -> respcyc/resp drop to 0 before the next edge; next read after reset completes normally with 8 beats.
REQ-024 Second reqcyc held high during a read, plus a tag with an unsupported device -> second request acked only after return to IDLE; unsupported request acked once with no respcyc.
